kf8259_inta_sequencer: RTL and testbench
========================================

KF8259_INTA_SEQUENCER -- requirements
Module: kf8259_inta_sequencer

Interface
REQ-001 The module SHALL have one clock, `clock`; reset is synchronous and active-high, named `reset`.
REQ-002 `clock` SHALL be an input, 1 bit: the system clock; all state SHALL update on its rising edge.
REQ-003 `reset` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 `interrupt` SHALL be an input, 8 bits: one-hot winning request from the priority resolver; 0 means no request.
REQ-005 `interrupt_acknowledge_n` SHALL be an input, 1 bit: CPU INTA#, active low, sampled on `clock`.
REQ-006 `end_of_interrupt` SHALL be an input, 8 bits: one-hot or multi-hot ISR clear request from the command decoder, valid for one cycle.
REQ-007 `auto_eoi_config` SHALL be an input, 1 bit: 1 selects automatic EOI.
REQ-008 `u8086_mode` SHALL be an input, 1 bit: 1 selects the 8086 two-pulse sequence; 0 selects the 8080 three-pulse sequence.
REQ-009 `vector_base` SHALL be an input, 5 bits: T7..T3 of the 8086 vector.
REQ-010 `call_address_low` SHALL be an input, 3 bits: A7..A5 of the 8080 CALL target.
REQ-011 `call_address_high` SHALL be an input, 8 bits: A15..A8 of the 8080 CALL target.
REQ-012 `interrupt_to_cpu` SHALL be an output, 1 bit: the INT pin.
REQ-013 `in_service_register` SHALL be an output, 8 bits: the ISR, fed back to the resolver.
REQ-014 `data_bus_out` SHALL be an output, 8 bits: the byte driven during an acknowledge.
REQ-015 `data_bus_out_enable` SHALL be an output, 1 bit: 1 while `data_bus_out` is valid.

Function
REQ-016 The block SHALL register `interrupt_acknowledge_n` once; a falling edge is previous=1 and current=0, and a rising edge is previous=0 and current=1.
REQ-017 It SHALL use the FSM states IDLE, ACK1, ACK2 and ACK3, each naming the INTA pulse currently in progress.
REQ-018 In IDLE, `interrupt_to_cpu` SHALL be set on the cycle after `interrupt`!=0 is observed, and SHALL stay high until the first falling edge.
REQ-019 On the first falling edge, the FSM SHALL go IDLE->ACK1, clear `interrupt_to_cpu`, latch the 3-bit level from `interrupt`, and set ISR |= `interrupt`.
REQ-020 If `interrupt`==0 at the first falling edge, it is a spurious request: the latched level SHALL be 7 and the ISR SHALL be left unchanged.
REQ-021 Each subsequent falling edge SHALL advance the FSM ACK1->ACK2, and in 8080 mode ACK2->ACK3.
REQ-022 The rising edge that ends the last pulse (ACK2 in 8086 mode, ACK3 in 8080 mode) SHALL return the FSM to IDLE.
REQ-023 Bytes SHALL be driven as follows:
- 8086 ACK1: nothing, enable=0.
- 8086 ACK2: {vector_base, level}.
- 8080 ACK1: 8'hCD.
- 8080 ACK2: {call_address_low, level, 2'b00}.
- 8080 ACK3: call_address_high.
REQ-024 `data_bus_out` and `data_bus_out_enable` SHALL be registered: valid from the cycle after the falling edge until the cycle after the rising edge of the same pulse; otherwise enable=0 and data=8'h00.
REQ-025 Latency SHALL be one clock from a sampled INTA edge to the output change.
REQ-026 Auto-EOI: when `auto_eoi_config`=1, the latched ISR bit SHALL be cleared on the rising edge that ends the last pulse.
REQ-027 Normal EOI: ISR &= ~`end_of_interrupt` SHALL be applied every cycle, in any state.
REQ-028 When set and clear hit the same ISR bit in the same cycle, the set SHALL win.
REQ-029 A change of `u8086_mode` mid-sequence SHALL take effect only from the next IDLE; the mode SHALL be latched at the first falling edge.
REQ-030 A new `interrupt` value during ACKn SHALL NOT alter the latched level and SHALL NOT re-raise INT until IDLE.
REQ-031 A falling edge while in the final state before its rising edge is impossible; extra falling edges in IDLE with `interrupt_to_cpu`=0 SHALL still start a sequence, handled as spurious per REQ-020.

Reset
REQ-032 Reset SHALL force: FSM=IDLE; `interrupt_to_cpu`=0; ISR=8'h00; `data_bus_out`=8'h00; `data_bus_out_enable`=0; latched level=0; INTA sample=1.
REQ-033 Reset mid-sequence SHALL abandon the sequence with no byte emitted on the following cycle.

Structure
REQ-034 The FSM state encoding, the CALL opcode constant 8'hCD, and the one-hot-to-index function SHALL reside in the shared package kf8259_common_package.
REQ-035 There SHALL be one sub-module, kf8259_edge_detector (1-bit registered sample with rise/fall pulses), reused for INTA#.

Verification
REQ-036 8086 mode, interrupt=8'h08, vector_base=5'h09: two INTA pulses -> ISR=8'h08 after pulse 1, byte 8'h4B during pulse 2, enable=0 during pulse 1.
REQ-037 8080 mode, interrupt=8'h02, call_address_low=3'b101, call_address_high=8'h12: three pulses -> bytes 8'hCD, 8'hA4, 8'h12 in order.
REQ-038 Auto-EOI with interrupt=8'h01 -> ISR=8'h01 during ACK1/ACK2 and 8'h00 one cycle after the final rising edge.
REQ-039 Spurious: assert INT via interrupt=8'h20, then drop interrupt to 0 before INTA, 8086 mode, vector_base=5'h00 -> byte 8'h07 and ISR stays 8'h00.
REQ-040 Simultaneous: ISR=8'h04, end_of_interrupt=8'h04 in the same cycle as a first falling edge with interrupt=8'h04 -> ISR=8'h04.
REQ-041 Reset asserted during 8080 ACK2 -> next cycle FSM=IDLE, ISR=8'h00, enable=0, INT=0.

Source files
------------

// File: rtl/kf8259_common_package.sv
// kf8259_common_package: shared INTA sequencer state encoding, CALL opcode and one-hot index helper.
package kf8259_common_package;
   typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;
   localparam logic [7:0] CALL_OPCODE = 8'hCD;
   function automatic logic [2:0] one_hot_to_index(input logic [7:0] one_hot);
      logic [2:0] index;
      index = 3'd0;
      for (int i = 0; i < 8; i++)
         if (one_hot[i]) index = 3'(i);
      return index;
   endfunction
endpackage

// File: rtl/kf8259_edge_detector.sv
// kf8259_edge_detector: registered sample of a 1-bit signal with combinational rise/fall pulses.
module kf8259_edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic signal,
   output logic rise,
   output logic fall
);
   logic previous;
   always_ff @(posedge clock)
      if (reset) previous <= 1'b1;
      else previous <= signal;
   assign rise = ~previous & signal;
   assign fall = previous & ~signal;
endmodule

// File: rtl/kf8259_inta_sequencer.sv
// kf8259_inta_sequencer: drives INT, runs the 8080/8086 INTA pulse sequence and maintains the ISR.
module kf8259_inta_sequencer
   import kf8259_common_package::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       interrupt_acknowledge_n,
   input  logic [7:0] end_of_interrupt,
   input  logic       auto_eoi_config,
   input  logic       u8086_mode,
   input  logic [4:0] vector_base,
   input  logic [2:0] call_address_low,
   input  logic [7:0] call_address_high,
   output logic       interrupt_to_cpu,
   output logic [7:0] in_service_register,
   output logic [7:0] data_bus_out,
   output logic       data_bus_out_enable
);
   logic       inta_rise, inta_fall;
   state_t     state;
   logic       mode_8086;
   logic [2:0] level;
   logic [7:0] acked;
   logic       last_rise;
   logic [7:0] isr_set, isr_auto_clear;

   kf8259_edge_detector u_inta_edge (
      .clock (clock),
      .reset (reset),
      .signal(interrupt_acknowledge_n),
      .rise  (inta_rise),
      .fall  (inta_fall)
   );

   assign last_rise      = inta_rise & ((state == ACK2 & mode_8086) | state == ACK3);
   assign isr_set        = (state == IDLE & inta_fall) ? interrupt : 8'h00;
   // acked is zero for a spurious request, so auto-EOI never clears a bit it did not set
   assign isr_auto_clear = (last_rise & auto_eoi_config) ? acked : 8'h00;

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= IDLE;
         interrupt_to_cpu    <= 1'b0;
         in_service_register <= 8'h00;
         data_bus_out        <= 8'h00;
         data_bus_out_enable <= 1'b0;
         level               <= 3'd0;
         acked               <= 8'h00;
         mode_8086           <= 1'b0;
      end else begin
         in_service_register <= (in_service_register & ~end_of_interrupt & ~isr_auto_clear) | isr_set;
         case (state)
            IDLE:
               if (inta_fall) begin
                  state               <= ACK1;
                  interrupt_to_cpu    <= 1'b0;
                  mode_8086           <= u8086_mode;
                  level               <= (|interrupt) ? one_hot_to_index(interrupt) : 3'd7;
                  acked               <= interrupt;
                  data_bus_out        <= u8086_mode ? 8'h00 : CALL_OPCODE;
                  data_bus_out_enable <= ~u8086_mode;
               end else begin
                  interrupt_to_cpu <= interrupt_to_cpu | (|interrupt);
               end
            ACK1:
               if (inta_rise) begin
                  data_bus_out        <= 8'h00;
                  data_bus_out_enable <= 1'b0;
               end else if (inta_fall) begin
                  state               <= ACK2;
                  data_bus_out        <= mode_8086 ? {vector_base, level} : {call_address_low, level, 2'b00};
                  data_bus_out_enable <= 1'b1;
               end
            ACK2:
               if (inta_rise) begin
                  data_bus_out        <= 8'h00;
                  data_bus_out_enable <= 1'b0;
                  if (mode_8086) state <= IDLE;
               end else if (inta_fall & ~mode_8086) begin
                  state               <= ACK3;
                  data_bus_out        <= call_address_high;
                  data_bus_out_enable <= 1'b1;
               end
            ACK3:
               if (inta_rise) begin
                  state               <= IDLE;
                  data_bus_out        <= 8'h00;
                  data_bus_out_enable <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// tb_kf8259_inta_sequencer: vector-table bench with an expected-output queue for the INTA sequencer.
module tb_kf8259_inta_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] interrupt = 8'h00;
   logic       interrupt_acknowledge_n = 1'b1;
   logic [7:0] end_of_interrupt = 8'h00;
   logic       auto_eoi_config = 1'b0;
   logic       u8086_mode = 1'b1;
   logic [4:0] vector_base = 5'h00;
   logic [2:0] call_address_low = 3'd0;
   logic [7:0] call_address_high = 8'h00;
   logic       interrupt_to_cpu;
   logic [7:0] in_service_register;
   logic [7:0] data_bus_out;
   logic       data_bus_out_enable;

   kf8259_inta_sequencer dut (
      .clock                  (clock),
      .reset                  (reset),
      .interrupt              (interrupt),
      .interrupt_acknowledge_n(interrupt_acknowledge_n),
      .end_of_interrupt       (end_of_interrupt),
      .auto_eoi_config        (auto_eoi_config),
      .u8086_mode             (u8086_mode),
      .vector_base            (vector_base),
      .call_address_low       (call_address_low),
      .call_address_high      (call_address_high),
      .interrupt_to_cpu       (interrupt_to_cpu),
      .in_service_register    (in_service_register),
      .data_bus_out           (data_bus_out),
      .data_bus_out_enable    (data_bus_out_enable)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       rst;
      logic [7:0] irq;
      logic       inta_n;
      logic [7:0] eoi;
      logic       aeoi;
      logic       m86;
      logic [4:0] vb;
      logic [2:0] cl;
      logic [7:0] ch;
      logic [7:0] isr;
      logic       intr;
      logic       en;
      logic [7:0] data;
   } vec_t;

   vec_t        tbl[$];
   logic [17:0] exp_q[$];
   int          n_vec = 0;
   int          n_miss = 0;

   function automatic vec_t mk(input logic rst, input logic [7:0] irq, input logic inta_n, input logic [7:0] eoi,
                               input logic aeoi, input logic m86, input logic [4:0] vb, input logic [2:0] cl,
                               input logic [7:0] ch, input logic [7:0] isr, input logic intr, input logic en,
                               input logic [7:0] data);
      vec_t v;
      v.rst = rst; v.irq = irq; v.inta_n = inta_n; v.eoi = eoi; v.aeoi = aeoi; v.m86 = m86;
      v.vb = vb; v.cl = cl; v.ch = ch; v.isr = isr; v.intr = intr; v.en = en; v.data = data;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      logic [17:0] got, exp;
      @(negedge clock);
      reset = v.rst; interrupt = v.irq; interrupt_acknowledge_n = v.inta_n; end_of_interrupt = v.eoi;
      auto_eoi_config = v.aeoi; u8086_mode = v.m86; vector_base = v.vb;
      call_address_low = v.cl; call_address_high = v.ch;
      exp_q.push_back({v.isr, v.intr, v.en, v.data});
      @(posedge clock);
      #1;
      got = {in_service_register, interrupt_to_cpu, data_bus_out_enable, data_bus_out};
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL vec%0d: got isr=%h int=%b en=%b data=%h, expected isr=%h int=%b en=%b data=%h",
                  n_vec, got[17:10], got[9], got[8], got[7:0], exp[17:10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   initial begin
      // 8086 two-pulse, vector 0x4B; new request during ACK2 must not raise INT
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h08, 1, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h08, 0, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h08, 0, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 1, 8'h4B));
      tbl.push_back(mk(0, 8'h10, 0, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 1, 8'h4B));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h09, 3'd0, 8'h00, 8'h08, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h08, 0, 1, 5'h09, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      // 8080 three-pulse; mode input flips mid-sequence and must be ignored
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h02, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h02, 0, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h02, 0, 1, 8'hCD));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd5, 8'h12, 8'h02, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h00, 3'd5, 8'h12, 8'h02, 0, 1, 8'hA4));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd5, 8'h12, 8'h02, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h00, 3'd5, 8'h12, 8'h02, 0, 1, 8'h12));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd5, 8'h12, 8'h02, 0, 0, 8'h00));
      // auto-EOI clears the ISR bit right after the final rising edge
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h01, 1, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h01, 0, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h01, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h01, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h01, 0, 1, 8'hF8));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 1, 1, 5'h1F, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      // spurious: request withdrawn before INTA gives level 7 and no ISR bit
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h20, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 1, 8'h07));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      // set and EOI clear on the same bit: set wins; EOI still acts mid-sequence
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h04, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h04, 0, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 0, 1, 8'h02));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h04, 1, 8'h00, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h04, 0, 8'h04, 0, 1, 5'h00, 3'd0, 8'h00, 8'h04, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h04, 0, 1, 5'h00, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      // reset during 8080 ACK2, then a stray falling edge starts a spurious sequence
      tbl.push_back(mk(1, 8'h00, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h80, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 1, 0, 8'h00));
      tbl.push_back(mk(0, 8'h80, 0, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h80, 0, 1, 8'hCD));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h80, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h80, 0, 1, 8'hBC));
      tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 0, 8'h00));
      tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 1, 8'hCD));
      tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0, 5'h00, 3'd5, 8'h12, 8'h00, 0, 0, 8'h00));
      foreach (tbl[i]) apply(tbl[i]);
      // hand-written sweep: every level through an auto-EOI 8086 sequence
      apply(mk(1, 8'h00, 1, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      for (int k = 0; k < 8; k++) begin
         logic [7:0] irq, vec;
         irq = 8'h01 << k;
         vec = 8'hA8 + 8'(k);
         apply(mk(0, irq,   1, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, 8'h00, 1, 0, 8'h00));
         apply(mk(0, irq,   0, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, irq,   0, 0, 8'h00));
         apply(mk(0, 8'h00, 1, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, irq,   0, 0, 8'h00));
         apply(mk(0, 8'h00, 0, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, irq,   0, 1, vec));
         apply(mk(0, 8'h00, 1, 8'h00, 1, 1, 5'h15, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
